// File: rtl/clock_time_setter_if.sv
// Button, running-time and edit/commit signals shared by the time setter and its neighbours.
// Buttons are raw active-low pins, all time digits are BCD.
interface clock_time_setter_if;
   logic       btn_mode;
   logic       btn_up;
   logic       btn_down;
   logic [3:0] cur_hour_tens;
   logic [3:0] cur_hour_units;
   logic [3:0] cur_min_tens;
   logic [3:0] cur_min_units;
   logic [3:0] set_hour_tens;
   logic [3:0] set_hour_units;
   logic [3:0] set_min_tens;
   logic [3:0] set_min_units;
   logic       load;
   logic       editing;
   logic [1:0] field;

   modport dut (
      input  btn_mode, btn_up, btn_down,
      input  cur_hour_tens, cur_hour_units, cur_min_tens, cur_min_units,
      output set_hour_tens, set_hour_units, set_min_tens, set_min_units,
      output load, editing, field
   );

   modport tb (
      output btn_mode, btn_up, btn_down,
      output cur_hour_tens, cur_hour_units, cur_min_tens, cur_min_units,
      input  set_hour_tens, set_hour_units, set_min_tens, set_min_units,
      input  load, editing, field
   );
endinterface

// File: rtl/clock_time_setter.sv
// Debounced three-button HH:MM editor; press reaches the FSM 2+DEBOUNCE_CYCLES+1 cycles after the pin settles.
// No backpressure: load is a one-cycle strobe the counters must take, events in RUN/COMMIT are dropped.
module clock_time_setter #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned TIMEOUT_CYCLES  = 500000000
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   clock_time_setter_if.dut  bus
);
   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {RUN, EDIT_HOUR, EDIT_MIN, COMMIT} state_t;

   // Bit 2 = mode, bit 1 = up, bit 0 = down.
   logic [2:0]      btn_raw;
   logic [2:0]      sync0_q, sync1_q;
   logic [2:0]      deb_q, deb_d;
   logic [2:0]      ev_q, ev_d;
   logic [DB_W-1:0] cnt_q [3];
   logic [DB_W-1:0] cnt_d [3];

   assign btn_raw = {bus.btn_mode, bus.btn_up, bus.btn_down};

   always_comb begin
      deb_d = deb_q;
      for (int i = 0; i < 3; i++) begin
         cnt_d[i] = '0;
         if (sync1_q[i] != deb_q[i]) begin
            if (cnt_q[i] == DB_LAST) deb_d[i] = sync1_q[i];
            else                     cnt_d[i] = cnt_q[i] + DB_W'(1);
         end
      end
      ev_d = deb_q & ~deb_d;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync0_q <= '1;
         sync1_q <= '1;
         deb_q   <= '1;
         ev_q    <= '0;
         for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
      end else begin
         sync0_q <= btn_raw;
         sync1_q <= sync0_q;
         deb_q   <= deb_d;
         ev_q    <= ev_d;
         for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   logic ev_mode, ev_up, ev_down;
   assign ev_mode = ev_q[2];
   assign ev_up   = ev_q[1];
   assign ev_down = ev_q[0];

   // Values packed {tens, units}.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [3:0] t_max, input logic [3:0] u_max);
      if (v[7:4] == t_max && v[3:0] == u_max) return 8'h00;
      if (v[3:0] == 4'd9)                     return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [3:0] t_max, input logic [3:0] u_max);
      if (v == 8'h00)        return {t_max, u_max};
      if (v[3:0] == 4'd0)    return {v[7:4] - 4'd1, 4'd9};
      return {v[7:4], v[3:0] - 4'd1};
   endfunction

   logic       hour_ok, min_ok;
   logic [7:0] hour_cap, min_cap;

   assign hour_ok  = (bus.cur_hour_units <= 4'd9) &&
                     ((bus.cur_hour_tens < 4'd2) || (bus.cur_hour_tens == 4'd2 && bus.cur_hour_units <= 4'd3));
   assign min_ok   = (bus.cur_min_tens <= 4'd5) && (bus.cur_min_units <= 4'd9);
   assign hour_cap = hour_ok ? {bus.cur_hour_tens, bus.cur_hour_units} : 8'h00;
   assign min_cap  = min_ok  ? {bus.cur_min_tens,  bus.cur_min_units}  : 8'h00;

   state_t          state_q;
   logic [7:0]      hour_q, min_q;
   logic            load_q, editing_q;
   logic [1:0]      field_q;
   logic [TO_W-1:0] tmo_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= RUN;
         hour_q    <= 8'h00;
         min_q     <= 8'h00;
         load_q    <= 1'b0;
         editing_q <= 1'b0;
         field_q   <= 2'd0;
         tmo_q     <= '0;
      end else begin
         load_q <= 1'b0;
         case (state_q)
            RUN: begin
               if (ev_mode) begin
                  hour_q    <= hour_cap;
                  min_q     <= min_cap;
                  state_q   <= EDIT_HOUR;
                  editing_q <= 1'b1;
                  field_q   <= 2'd1;
                  tmo_q     <= '0;
               end
            end
            EDIT_HOUR, EDIT_MIN: begin
               if (ev_mode) begin
                  tmo_q <= '0;
                  if (state_q == EDIT_HOUR) begin
                     state_q <= EDIT_MIN;
                     field_q <= 2'd2;
                  end else begin
                     state_q   <= COMMIT;
                     load_q    <= 1'b1;
                     editing_q <= 1'b0;
                     field_q   <= 2'd0;
                  end
               end else if (ev_up || ev_down) begin
                  // Coincident up+down cancel out but still count as activity.
                  tmo_q <= '0;
                  if (ev_up ^ ev_down) begin
                     if (state_q == EDIT_HOUR)
                        hour_q <= ev_up ? bcd_inc(hour_q, 4'd2, 4'd3) : bcd_dec(hour_q, 4'd2, 4'd3);
                     else
                        min_q  <= ev_up ? bcd_inc(min_q, 4'd5, 4'd9) : bcd_dec(min_q, 4'd5, 4'd9);
                  end
               end else if (tmo_q == TO_LAST) begin
                  state_q   <= RUN;
                  editing_q <= 1'b0;
                  field_q   <= 2'd0;
                  tmo_q     <= '0;
               end else begin
                  tmo_q <= tmo_q + TO_W'(1);
               end
            end
            COMMIT:  state_q <= RUN;
            default: state_q <= RUN;
         endcase
      end
   end

   assign bus.set_hour_tens  = hour_q[7:4];
   assign bus.set_hour_units = hour_q[3:0];
   assign bus.set_min_tens   = min_q[7:4];
   assign bus.set_min_units  = min_q[3:0];
   assign bus.load           = load_q;
   assign bus.editing        = editing_q;
   assign bus.field          = field_q;
endmodule

// File: doc/clock_time_setter.md
# clock_time_setter

Button-driven time-setting controller for the clock: the input-side counterpart of the BCD-to-seven-segment display path. It debounces three push-buttons and runs an edit state machine that captures the running HH:MM, lets the user step hours and minutes up and down, and emits a one-cycle load strobe with the new BCD time for the hour/minute counters. It sits beside the 1 Hz counter chain on the 50 MHz board clock.

## Interface
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples needed to accept a new button level (20 ms at 50 MHz)
- TIMEOUT_CYCLES, 500000000, idle cycles in an edit state before the edit is abandoned (10 s)
- clk  input  1  board clock, 50 MHz, all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- btn_mode  input  1  mode key, active-low, asynchronous to clk
- btn_up  input  1  increment key, active-low, asynchronous
- btn_down  input  1  decrement key, active-low, asynchronous
- cur_hour_tens, cur_hour_units, cur_min_tens, cur_min_units  input  4 each  running time, BCD
- set_hour_tens, set_hour_units, set_min_tens, set_min_units  output  4 each  edit/commit value, BCD
- load  output  1  one-cycle strobe: counters take set_* and clear seconds
- editing  output  1  high in EDIT_HOUR and EDIT_MIN
- field  output  2  0 = none, 1 = hours selected, 2 = minutes selected (drives display blink)

## Operation
- Each button: 2-FF synchronizer, then debouncer. The debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles. Any mismatch-free cycle restarts the count.
- A press event is a one-cycle pulse on the debounced 1->0 transition. Release generates no event. There is no auto-repeat.
- FSM states: RUN, EDIT_HOUR, EDIT_MIN, COMMIT.
- RUN + mode event: capture the cur_* inputs into the set_* registers and go to EDIT_HOUR.
  - If the captured hour is greater than 23, or any digit is greater than 9, the corresponding field (HH or MM) is captured as 00.
- EDIT_HOUR:
  - up event: hour +1, wrapping 23 -> 00.
  - down event: hour -1, wrapping 00 -> 23.
  - mode event: go to EDIT_MIN.
- EDIT_MIN:
  - up event: minute +1, wrapping 59 -> 00.
  - down event: minute -1, wrapping 00 -> 59.
  - mode event: go to COMMIT.
- COMMIT: load=1 for exactly one cycle, then go to RUN.
- Arithmetic is pure BCD: units roll 9->0 with a carry into tens, and 0->9 with a borrow. Tens is 0-2 for hours and 0-5 for minutes. Binary intermediates are never exposed on set_*.
- Timeout: a counter clears on every press event and on entering an edit state. If it reaches TIMEOUT_CYCLES in EDIT_HOUR or EDIT_MIN, go to RUN with no load; set_* hold their values.
- Simultaneous events in the same cycle:
  - mode with up or down: mode wins; up/down is ignored.
  - up and down together: both ignored. They still restart the timeout.
- Events arriving in RUN other than mode, and all events arriving in COMMIT, are ignored.
- set_* hold their last value in RUN. They are updated only on capture and on up/down.

## Timing
- Reset (rst=0, asynchronous):
  - state RUN; load=0, editing=0, field=0.
  - set_* all 0.
  - debounced levels 1 (released); debounce and timeout counters 0.
- Press latency: from a stable 0 at the pin to the event pulse is 2 synchronizer cycles + DEBOUNCE_CYCLES + 1, within ±1 cycle.
- Event processing:
  - An event in cycle N changes the state and the set_* values visible in cycle N+1.
  - editing and field are registered and follow the state in the same cycle.
- COMMIT:
  - Entered at N+1 after the mode event in EDIT_MIN, with load=1 in that cycle.
  - RUN follows at N+2 with load=0.
  - set_* are stable throughout the load cycle.
- Reset mid-edit: the edit is abandoned immediately, load is never asserted, and outputs take their reset values.
- A bounce shorter than DEBOUNCE_CYCLES produces no event and no state change.

## Test plan
Settings: DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=200.
- Reset: hold rst=0 with buttons released -> load=0, editing=0, field=0, set_*=0000. Release reset and idle 50 cycles -> no change.
- Bounce rejection: btn_up toggles 0/1 every 2 cycles for 40 cycles while in EDIT_HOUR with 12 captured -> hour stays 12. Then a clean press held 10 cycles -> hour 13, exactly one increment.
- Full edit sequence:
  - cur=23:58, then mode, up, mode, up, up, mode.
  - Hour wraps 23->00; minute goes 58->59->00.
  - load pulses once with set=00:00, field sequence 1,2,0, editing drops with the load cycle.
- Decrement wraps:
  - From captured 00:00, down in EDIT_HOUR -> 23.
  - Then mode, down -> minute 59.
  - Then down x10 -> 49, checking the tens borrow.
- Timeout: enter EDIT_MIN and idle 200 cycles -> state RUN, load never asserted, set_* retain the edited value.
- Conflicts and reset:
  - up and down pressed in the same cycle -> value unchanged.
  - mode and up together in EDIT_HOUR -> EDIT_MIN with hour unchanged.
  - rst=0 asserted in EDIT_MIN -> immediate reset values, no load.
